// File: rtl/mod_barrett_precompute_32b_pkg.sv
// rtl/mod_barrett_precompute_32b_pkg.sv - shared widths and FSM encodings for the Barrett precompute block
package mod_barrett_precompute_32b_pkg;

  // Modulus width, width of K (0..DW), width of U (2*DW)
  localparam int DW = 32;
  localparam int KW = 6;
  localparam int UW = 64;

  // Dividend/quotient width (2^(2K) needs bit 64) and division bit counter width
  localparam int XW = UW + 1;
  localparam int CW = 7;

  // Index of the first (most significant) dividend bit processed by the divider
  localparam logic [CW-1:0] DIV_FIRST_BIT = CW'(UW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_barrett_precompute_32b_if.sv
// rtl/mod_barrett_precompute_32b_if.sv - control and result bundle between requester and precompute block
interface mod_barrett_precompute_32b_if;
  import mod_barrett_precompute_32b_pkg::*;

  logic          iEn;
  logic          iClr;
  logic          iStart;
  logic [DW-1:0] iMod;
  logic          oBusy;
  logic          oDone;
  logic          oErr;
  logic [KW-1:0] oK;
  logic [UW-1:0] oU;

  // Requester side: drives the modulus and controls, consumes K/U
  modport master (
    output iEn, iClr, iStart, iMod,
    input  oBusy, oDone, oErr, oK, oU
  );

  // Precompute block side
  modport slave (
    input  iEn, iClr, iStart, iMod,
    output oBusy, oDone, oErr, oK, oU
  );

endinterface

// File: rtl/mod_barrett_precompute_32b_lod.sv
// rtl/mod_barrett_precompute_32b_lod.sv - combinational leading-one detector for a 32-bit word
module leading_one_detector_32b (
  input  logic [31:0] iVec,
  output logic [4:0]  oIdx,
  output logic        oValid
);

  // Scan upward so the highest set bit is the last one to win
  always_comb begin
    oIdx   = 5'd0;
    oValid = |iVec;
    for (int i = 0; i < 32; i++) begin
      if (iVec[i]) oIdx = 5'(i);
    end
  end

endmodule

// File: rtl/mod_barrett_precompute_32b.sv
// rtl/mod_barrett_precompute_32b.sv - bit-serial computation of Barrett operands K and U from modulus q
module mod_barrett_precompute_32b
  import mod_barrett_precompute_32b_pkg::*;
(
  input logic                          iClk,
  input logic                          iRst,
  mod_barrett_precompute_32b_if.slave  bus
);

  logic          clr;
  state_t        state, state_nx;
  logic          do_accept, do_norm, do_step, do_finish;

  logic [DW-1:0] q_reg;
  logic [KW-1:0] k_reg;
  logic          err_reg;
  logic [XW-1:0] div_reg;
  logic [XW-1:0] quo_reg;
  logic [DW:0]   rem_reg;
  logic [CW-1:0] cnt_reg;

  logic          busy_q, done_q, err_q;
  logic [KW-1:0] k_q;
  logic [UW-1:0] u_q;

  logic [4:0]    msb_idx;
  logic          msb_valid;
  logic [KW-1:0] k_nx;
  logic [XW-1:0] dividend_nx;
  logic [DW+1:0] rem_sh;
  logic [DW+1:0] q_ext;
  logic          rem_ge;
  logic [DW:0]   rem_nx;

  assign clr = iRst | bus.iClr;

  leading_one_detector_32b u_lod (
    .iVec   (q_reg),
    .oIdx   (msb_idx),
    .oValid (msb_valid)
  );

  // Normalisation: K = bit length of q, dividend = 2^(2K)
  assign k_nx        = KW'(msb_idx) + KW'(1);
  assign dividend_nx = XW'(1) << {k_nx, 1'b0};

  // One restoring step: bring down the next dividend bit, subtract q when it fits
  assign rem_sh = {1'b0, rem_reg, div_reg[cnt_reg]};
  assign q_ext  = {2'b00, q_reg};
  assign rem_ge = (rem_sh >= q_ext);
  assign rem_nx = rem_ge ? (DW+1)'(rem_sh - q_ext) : rem_sh[DW:0];

  // State register
  always_ff @(posedge iClk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; nothing advances while iEn is low
  always_comb begin
    state_nx = state;
    if (bus.iEn) begin
      case (state)
        ST_IDLE: if (bus.iStart) state_nx = ST_NORM;
        ST_NORM: state_nx = msb_valid ? ST_DIV : ST_DONE;
        ST_DIV:  if (cnt_reg == '0) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    do_accept = bus.iEn && (state == ST_IDLE) && bus.iStart;
    do_norm   = bus.iEn && (state == ST_NORM);
    do_step   = bus.iEn && (state == ST_DIV);
    do_finish = bus.iEn && (state == ST_DONE);
  end

  // Division datapath and result registers; results only change on finish
  always_ff @(posedge iClk) begin
    if (clr) begin
      q_reg   <= '0;
      k_reg   <= '0;
      err_reg <= 1'b0;
      div_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      cnt_reg <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      u_q     <= '0;
    end else begin
      if (bus.iEn) done_q <= do_finish;
      if (do_accept) begin
        q_reg  <= bus.iMod;
        busy_q <= 1'b1;
      end
      if (do_norm) begin
        rem_reg <= '0;
        quo_reg <= '0;
        cnt_reg <= DIV_FIRST_BIT;
        if (msb_valid) begin
          k_reg   <= k_nx;
          err_reg <= 1'b0;
          div_reg <= dividend_nx;
        end else begin
          k_reg   <= '0;
          err_reg <= 1'b1;
          div_reg <= '0;
        end
      end
      if (do_step) begin
        rem_reg <= rem_nx;
        quo_reg <= {quo_reg[UW-1:0], rem_ge};
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (do_finish) begin
        assert (quo_reg[UW] == 1'b0);
        busy_q <= 1'b0;
        err_q  <= err_reg;
        k_q    <= k_reg;
        u_q    <= err_reg ? '0 : quo_reg[UW-1:0];
      end
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oErr  = err_q;
  assign bus.oK    = k_q;
  assign bus.oU    = u_q;

endmodule

// File: tb/tb_mod_barrett_precompute_32b.sv
// tb/tb_mod_barrett_precompute_32b.sv - randomized self-checking bench for the Barrett precompute block
module tb_mod_barrett_precompute_32b;
  import mod_barrett_precompute_32b_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mod_barrett_precompute_32b_if bus ();

  mod_barrett_precompute_32b dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  // Reference: K = bit length of q, U = floor(2^(2K)/q) in wide arithmetic
  function automatic void model(input logic [31:0] q, output logic [5:0] k,
                                output logic [63:0] u, output logic e);
    logic [127:0] num;
    e   = (q == 32'd0);
    k   = e ? 6'd0 : 6'($clog2({32'd0, q} + 64'd1));
    num = 128'd1 << (2 * int'(k));
    u   = e ? 64'd0 : 64'(num / {96'd0, q});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      tick();
      n++;
      if (bus.oDone === 1'b1) seen = 1'b1;
    end
  endtask

  // Present q with iStart for exactly one edge; iMod is scrambled afterwards
  task automatic start_op(input logic [31:0] q);
    bus.iMod   = q;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iMod   = $urandom;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.iEn    = 1'b1;
    bus.iClr   = 1'b0;
    bus.iStart = 1'b1;
    bus.iMod   = 32'd12289;
    tick();
    tick();
    rst        = 1'b0;
    bus.iStart = 1'b0;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oErr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/err=%b required 000", {bus.oBusy, bus.oDone, bus.oErr});
    end
    checks++;
    if (bus.oK !== 6'd0 || bus.oU !== 64'd0) begin
      errors++;
      $display("FAIL reset_results: got K=%0d U=%0h required 0/0", bus.oK, bus.oU);
    end
    tick();
    checks++;
    if (bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_start: got busy=%b required 0", bus.oBusy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vq [5] = '{32'd12289, 32'd3329, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [5:0]  vk [5] = '{6'd14, 6'd12, 6'd1, 6'd32, 6'd32};
    logic [63:0] vu [5] = '{64'd21843, 64'd5039, 64'd4, 64'h1_0000_0001, 64'h2_0000_0000};
    int n;
    bit seen;
    logic [63:0] held;
    for (int i = 0; i < 5; i++) begin
      start_op(vq[i]);
      checks++;
      if (bus.oBusy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_busy: got %b required 1", i, bus.oBusy);
      end
      wait_done(200, n, seen);
      checks++;
      if (!seen || n != 67) begin
        errors++;
        $display("FAIL vec%0d_latency: got seen=%0d cycles=%0d required 67", i, seen, n);
      end
      checks++;
      if (bus.oK !== vk[i] || bus.oU !== vu[i] || bus.oErr !== 1'b0 || bus.oBusy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_result: got K=%0d U=%0h err=%b busy=%b required K=%0d U=%0h err=0 busy=0",
                 i, bus.oK, bus.oU, bus.oErr, bus.oBusy, vk[i], vu[i]);
      end
      held = bus.oU;
      tick();
      tick();
      checks++;
      if (bus.oDone !== 1'b0 || bus.oU !== held) begin
        errors++;
        $display("FAIL vec%0d_hold: got done=%b U=%0h required done=0 U=%0h", i, bus.oDone, bus.oU, held);
      end
    end
  endtask

  task automatic test_zero();
    int n;
    bit seen;
    start_op(32'd0);
    wait_done(200, n, seen);
    checks++;
    if (!seen || n != 2) begin
      errors++;
      $display("FAIL zero_latency: got seen=%0d cycles=%0d required 2", seen, n);
    end
    checks++;
    if (bus.oErr !== 1'b1 || bus.oK !== 6'd0 || bus.oU !== 64'd0) begin
      errors++;
      $display("FAIL zero_result: got err=%b K=%0d U=%0h required err=1 K=0 U=0", bus.oErr, bus.oK, bus.oU);
    end
    tick();
    start_op(32'd3329);
    wait_done(200, n, seen);
    checks++;
    if (!seen || bus.oErr !== 1'b0 || bus.oK !== 6'd12 || bus.oU !== 64'd5039) begin
      errors++;
      $display("FAIL zero_recover: got seen=%0d err=%b K=%0d U=%0d required err=0 K=12 U=5039",
               seen, bus.oErr, bus.oK, bus.oU);
    end
  endtask

  task automatic test_random();
    logic [31:0] q;
    logic [5:0]  mk;
    logic [63:0] mu;
    logic        me;
    int n;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      q = $urandom >> $urandom_range(0, 31);
      if (i == 11) q = 32'd0;
      model(q, mk, mu, me);
      start_op(q);
      wait_done(200, n, seen);
      checks++;
      if (!seen || n != (me ? 2 : 67)) begin
        errors++;
        $display("FAIL rand%0d_latency: q=%0h got seen=%0d cycles=%0d required %0d", i, q, seen, n, me ? 2 : 67);
      end
      checks++;
      if (bus.oK !== mk || bus.oU !== mu || bus.oErr !== me) begin
        errors++;
        $display("FAIL rand%0d_result: q=%0h got K=%0d U=%0h err=%b required K=%0d U=%0h err=%b",
                 i, q, bus.oK, bus.oU, bus.oErr, mk, mu, me);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_enable_stall();
    logic [31:0] q;
    logic [5:0]  mk;
    logic [63:0] mu;
    logic        me;
    int n;
    bit seen;
    q = $urandom | 32'h0000_0100;
    model(q, mk, mu, me);
    tick();
    start_op(q);
    repeat (20) tick();
    bus.iEn = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL stall_frozen: got busy=%b done=%b required busy=1 done=0", bus.oBusy, bus.oDone);
    end
    bus.iEn    = 1'b1;
    bus.iStart = 1'b1;
    bus.iMod   = q ^ 32'h0F0F_0F0F;
    repeat (3) tick();
    bus.iStart = 1'b0;
    wait_done(200, n, seen);
    checks++;
    if (!seen || (20 + 10 + 3 + n) != 77) begin
      errors++;
      $display("FAIL stall_latency: got seen=%0d cycles=%0d required 77", seen, 20 + 10 + 3 + n);
    end
    checks++;
    if (bus.oK !== mk || bus.oU !== mu || bus.oErr !== 1'b0) begin
      errors++;
      $display("FAIL stall_result: got K=%0d U=%0h err=%b required K=%0d U=%0h err=0",
               bus.oK, bus.oU, bus.oErr, mk, mu);
    end
    bus.iEn = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.oDone !== 1'b1) begin
      errors++;
      $display("FAIL done_stretch: got done=%b required 1", bus.oDone);
    end
    bus.iEn = 1'b1;
    tick();
    checks++;
    if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0 || bus.oU !== mu) begin
      errors++;
      $display("FAIL done_release: got done=%b busy=%b U=%0h required done=0 busy=0 U=%0h",
               bus.oDone, bus.oBusy, bus.oU, mu);
    end
  endtask

  task automatic test_clear();
    logic [31:0] q;
    logic [5:0]  mk;
    logic [63:0] mu;
    logic        me;
    int n;
    bit seen;
    for (int which = 0; which < 2; which++) begin
      start_op($urandom | 32'h0001_0000);
      repeat (30) tick();
      if (which == 0) bus.iClr = 1'b1;
      else            rst      = 1'b1;
      tick();
      bus.iClr = 1'b0;
      rst      = 1'b0;
      checks++;
      if ({bus.oBusy, bus.oDone, bus.oErr} !== 3'b000 || bus.oK !== 6'd0 || bus.oU !== 64'd0) begin
        errors++;
        $display("FAIL clear%0d_outputs: got busy/done/err=%b K=%0d U=%0h required all 0",
                 which, {bus.oBusy, bus.oDone, bus.oErr}, bus.oK, bus.oU);
      end
      wait_done(100, n, seen);
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL clear%0d_no_done: got done after %0d cycles required none", which, n);
      end
      q = $urandom >> $urandom_range(0, 20);
      q = q | 32'd1;
      model(q, mk, mu, me);
      start_op(q);
      wait_done(200, n, seen);
      checks++;
      if (!seen || n != 67 || bus.oK !== mk || bus.oU !== mu) begin
        errors++;
        $display("FAIL clear%0d_restart: got seen=%0d cycles=%0d K=%0d U=%0h required 67 K=%0d U=%0h",
                 which, seen, n, bus.oK, bus.oU, mk, mu);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q1, q2;
    logic [5:0]  k1, k2;
    logic [63:0] u1, u2;
    logic        e1, e2;
    int n;
    bit seen;
    q1 = $urandom | 32'h0000_1000;
    q2 = ($urandom >> 9) | 32'd3;
    model(q1, k1, u1, e1);
    model(q2, k2, u2, e2);
    bus.iMod   = q1;
    bus.iStart = 1'b1;
    tick();
    wait_done(200, n, seen);
    checks++;
    if (!seen || n != 67 || bus.oK !== k1 || bus.oU !== u1) begin
      errors++;
      $display("FAIL b2b_first: got seen=%0d cycles=%0d K=%0d U=%0h required 67 K=%0d U=%0h",
               seen, n, bus.oK, bus.oU, k1, u1);
    end
    bus.iMod = q2;
    tick();
    bus.iStart = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", bus.oBusy, bus.oDone);
    end
    wait_done(200, n, seen);
    checks++;
    if (!seen || n != 67 || bus.oK !== k2 || bus.oU !== u2 || bus.oErr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got seen=%0d cycles=%0d K=%0d U=%0h required 67 K=%0d U=%0h",
               seen, n, bus.oK, bus.oU, k2, u2);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.iEn    = 1'b0;
    bus.iClr   = 1'b0;
    bus.iStart = 1'b0;
    bus.iMod   = 32'd0;
    test_reset();
    test_vectors();
    test_zero();
    test_random();
    test_enable_stall();
    test_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
